// File: rtl/instruction_fetch_unit.sv
// Fetch stage of a five-stage MIPS pipeline: owns the PC, reads combinational
// instruction memory and loads the IF/ID register, with stall, flush, redirect and fault flag.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        AddrFault
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);

  logic [31:0] pc_plus4;
  logic        in_range;
  logic [31:0] fetched_word;
  logic        bubble;
  logic        capture;
  logic        misaligned_redirect;

  assign IMemAddress         = PC;
  assign pc_plus4            = PC + 32'd4;
  assign in_range            = (PC < MEM_LIMIT);
  // Out-of-range fetches deliver a nop rather than whatever the memory aliases to.
  assign fetched_word        = in_range ? IMemInstruction : 32'h0000_0000;
  assign bubble              = Flush || RedirectValid;
  assign capture             = !bubble && !Stall;
  assign misaligned_redirect = RedirectValid && (RedirectTarget[1:0] != 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC                <= RESET_PC;
      IF_ID_Instruction <= 32'h0000_0000;
      IF_ID_PCPlus4     <= 32'h0000_0000;
      IF_ID_Valid       <= 1'b0;
      AddrFault         <= 1'b0;
    end else begin
      // A redirect beats a stall: the hazard is moot once the path changes.
      if (RedirectValid) begin
        PC <= {RedirectTarget[31:2], 2'b00};
      end else if (!Stall) begin
        PC <= pc_plus4;
      end

      if (bubble) begin
        IF_ID_Instruction <= 32'h0000_0000;
        IF_ID_PCPlus4     <= 32'h0000_0000;
        IF_ID_Valid       <= 1'b0;
      end else if (capture) begin
        IF_ID_Instruction <= fetched_word;
        IF_ID_PCPlus4     <= pc_plus4;
        IF_ID_Valid       <= 1'b1;
      end

      if (misaligned_redirect || (capture && !in_range)) begin
        AddrFault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle reference model checked
// every negedge, plus literal expectations taken from hand-worked scenarios.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        AddrFault;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WORDS(128)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .RedirectValid    (RedirectValid),
    .RedirectTarget   (RedirectTarget),
    .IMemAddress      (IMemAddress),
    .IMemInstruction  (IMemInstruction),
    .PC               (PC),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .AddrFault        (AddrFault)
  );

  // Memory deliberately aliases beyond 128 words, so a missing range check shows up.
  logic [31:0] mem [0:127];
  assign IMemInstruction = mem[IMemAddress[8:2]];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference state: what the outputs must be after each edge.
  logic [31:0] m_pc, m_inst, m_pp4;
  logic        m_valid, m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("pc", PC, m_pc);
      check("imem_addr", IMemAddress, m_pc);
      check("ifid_inst", IF_ID_Instruction, m_inst);
      check("ifid_pp4", IF_ID_PCPlus4, m_pp4);
      check("ifid_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
      check("addr_fault", {31'd0, AddrFault}, {31'd0, m_fault});
    end
  end

  // One clock: drive inputs, advance the model from the fetch rules, settle past negedge.
  task automatic cycle(input logic rst, input logic stl, input logic fl,
                       input logic rv, input logic [31:0] tgt);
    logic [31:0] word, n_pc, n_inst, n_pp4;
    logic        n_valid, n_fault;
    Reset = rst; Stall = stl; Flush = fl; RedirectValid = rv; RedirectTarget = tgt;
    word = (m_pc < 32'd512) ? mem[m_pc[8:2]] : 32'd0;
    if (rst) begin
      n_pc = 32'd0; n_inst = 32'd0; n_pp4 = 32'd0; n_valid = 1'b0; n_fault = 1'b0;
    end else begin
      n_pc = rv ? (tgt & 32'hFFFF_FFFC) : (stl ? m_pc : m_pc + 32'd4);
      n_inst = m_inst; n_pp4 = m_pp4; n_valid = m_valid;
      if (fl || rv) begin
        n_inst = 32'd0; n_pp4 = 32'd0; n_valid = 1'b0;
      end else if (!stl) begin
        n_inst = word; n_pp4 = m_pc + 32'd4; n_valid = 1'b1;
      end
      n_fault = m_fault || (rv && tgt[1:0] != 2'b00)
                || (!fl && !rv && !stl && m_pc >= 32'd512);
    end
    @(posedge Clk);
    m_pc = n_pc; m_inst = n_inst; m_pp4 = n_pp4; m_valid = n_valid; m_fault = n_fault;
    @(negedge Clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0]   = 32'h3412_0000;
    mem[1]   = 32'h8E52_0000;
    mem[2]   = 32'h3413_0000;
    mem[127] = 32'h0000_0000;
    m_pc = 32'd0; m_inst = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; RedirectValid = 1'b0; RedirectTarget = 32'd0;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_en = 1'b1;
    check("reset_pc", PC, 32'h0);
    check("reset_valid", {31'd0, IF_ID_Valid}, 32'd0);
    check("reset_inst", IF_ID_Instruction, 32'h0);

    // Free-running fetch from address 0
    run(1);
    check("seq1_pc", PC, 32'h4);
    check("seq1_inst", IF_ID_Instruction, 32'h3412_0000);
    check("seq1_pp4", IF_ID_PCPlus4, 32'h4);
    run(1);
    check("seq2_inst", IF_ID_Instruction, 32'h8E52_0000);
    check("seq2_pc", PC, 32'h8);

    // Stall for three cycles at PC=8
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("stall_pc", PC, 32'h8);
    check("stall_inst", IF_ID_Instruction, 32'h8E52_0000);
    check("stall_pp4", IF_ID_PCPlus4, 32'h8);
    run(1);
    check("resume_pc", PC, 32'hC);
    check("resume_inst", IF_ID_Instruction, 32'h3413_0000);
    check("resume_pp4", IF_ID_PCPlus4, 32'hC);

    // Walk to 0xA8, then redirect to 0xB4
    run(39);
    check("walk_pc", PC, 32'hA8);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hB4);
    check("redir_pc", PC, 32'hB4);
    check("redir_bubble", {31'd0, IF_ID_Valid}, 32'd0);
    run(1);
    check("redir_inst", IF_ID_Instruction, 32'hA000_002D);
    check("redir_pp4", IF_ID_PCPlus4, 32'hB8);

    // Redirect beats stall; flush+stall holds PC and bubbles; flush alone advances
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hF4);
    check("redir_stall_pc", PC, 32'hF4);
    check("redir_stall_valid", {31'd0, IF_ID_Valid}, 32'd0);
    run(1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check("flush_stall_pc", PC, 32'hF8);
    check("flush_stall_valid", {31'd0, IF_ID_Valid}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("flush_pc", PC, 32'hFC);
    run(1);
    check("after_flush_inst", IF_ID_Instruction, 32'hA000_003F);

    // Misaligned redirect: sticky fault
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hB6);
    check("misalign_pc", PC, 32'hB4);
    check("misalign_fault", {31'd0, AddrFault}, 32'd1);
    run(10);
    check("fault_sticky", {31'd0, AddrFault}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
    check("reset_over_redir_pc", PC, 32'h0);
    check("fault_cleared", {31'd0, AddrFault}, 32'd0);
    run(1);
    check("post_reset_inst", IF_ID_Instruction, 32'h3412_0000);

    // Last word in range, then fetch past the end of memory
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1FC);
    run(1);
    check("last_word_inst", IF_ID_Instruction, 32'h0);
    check("last_word_valid", {31'd0, IF_ID_Valid}, 32'd1);
    check("last_word_pc", PC, 32'h200);
    run(1);
    check("oor_inst", IF_ID_Instruction, 32'h0);
    check("oor_pp4", IF_ID_PCPlus4, 32'h204);
    check("oor_fault", {31'd0, AddrFault}, 32'd1);
    run(2);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(1);
    check("wrap_pc", PC, 32'h0);
    check("wrap_pp4", IF_ID_PCPlus4, 32'h0);
    run(1);
    check("wrap_inst", IF_ID_Instruction, 32'h3412_0000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
